// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dram_port_arbiter
// Brief   : Round-robin arbiter sharing one single-port DRAM among N_REQ
//           cores. Optional bus lock enabled by macro DRAM_ARB_LOCK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module dram_port_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_we,
    input  logic [N_REQ-1:0]        i_lock,
    input  logic [N_REQ*ADDR_W-1:0] i_addr,
    input  logic [N_REQ*DATA_W-1:0] i_wdata,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [N_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]       o_rdata,
    output logic                    o_dram_en,
    output logic                    o_dram_we,
    output logic [ADDR_W-1:0]       o_dram_addr,
    output logic [DATA_W-1:0]       o_dram_wdata,
    input  logic [DATA_W-1:0]       i_dram_rdata,
    output logic                    o_busy
);
    localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_cnt_w = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_ptr_w-1:0] rr_ptr_q, rr_ptr_d;
    logic [c_ptr_w-1:0] winner_q, winner_d;
    logic [c_cnt_w-1:0] rd_cnt_q, rd_cnt_d;
    logic               req_we_q, req_we_d;
    logic               locked_q, locked_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               dram_en_q, dram_en_d;
    logic               dram_we_q, dram_we_d;
    logic [ADDR_W-1:0]  dram_addr_q, dram_addr_d;
    logic [DATA_W-1:0]  dram_wdata_q, dram_wdata_d;
    logic               busy_q, busy_d;

    logic               w_found;
    logic               w_lock_hit;
    logic [c_ptr_w-1:0] w_sel;

`ifdef DRAM_ARB_LOCK_EN
    // The previous winner keeps the bus while it holds both lock and request.
    assign w_lock_hit = i_lock[winner_q] & i_req[winner_q];
`else
    logic w_unused_lock;
    assign w_unused_lock = ^i_lock;
    assign w_lock_hit    = 1'b0;
`endif

    always_comb begin
        logic [c_ptr_w-1:0] idx;
        idx     = '0;
        w_found = 1'b0;
        w_sel   = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            idx = c_ptr_w'((int'(rr_ptr_q) + i) % N_REQ);
            if (!w_found && i_req[idx]) begin
                w_found = 1'b1;
                w_sel   = idx;
            end
        end
        if (w_lock_hit) begin
            w_found = 1'b1;
            w_sel   = winner_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        winner_d     = winner_q;
        rd_cnt_d     = rd_cnt_q;
        req_we_d     = req_we_q;
        locked_d     = locked_q;
        gnt_d        = '0;
        rvalid_d     = '0;
        rdata_d      = rdata_q;
        dram_en_d    = 1'b0;
        dram_we_d    = 1'b0;
        dram_addr_d  = dram_addr_q;
        dram_wdata_d = dram_wdata_q;

        case (state_q)
            IDLE: begin
                // Grant and DRAM strobes are registered here so they appear during ISSUE.
                if (w_found) begin
                    winner_d        = w_sel;
                    req_we_d        = i_we[w_sel];
                    locked_d        = w_lock_hit;
                    gnt_d[w_sel]    = 1'b1;
                    dram_en_d       = 1'b1;
                    dram_we_d       = i_we[w_sel];
                    dram_addr_d     = i_addr[int'(w_sel)*ADDR_W +: ADDR_W];
                    dram_wdata_d    = i_wdata[int'(w_sel)*DATA_W +: DATA_W];
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                if (!locked_q) begin
                    rr_ptr_d = c_ptr_w'((int'(winner_q) + 1) % N_REQ);
                end
                if (req_we_q) begin
                    state_d = IDLE;
                end else begin
                    rd_cnt_d = c_cnt_w'(RD_LAT);
                    state_d  = WAIT_RD;
                end
            end
            WAIT_RD: begin
                rd_cnt_d = rd_cnt_q - 1'b1;
                if (rd_cnt_q == c_cnt_w'(1)) begin
                    rdata_d            = i_dram_rdata;
                    rvalid_d[winner_q] = 1'b1;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            winner_q     <= '0;
            rd_cnt_q     <= '0;
            req_we_q     <= 1'b0;
            locked_q     <= 1'b0;
            gnt_q        <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            dram_en_q    <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= '0;
            dram_wdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            winner_q     <= winner_d;
            rd_cnt_q     <= rd_cnt_d;
            req_we_q     <= req_we_d;
            locked_q     <= locked_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            dram_en_q    <= dram_en_d;
            dram_we_q    <= dram_we_d;
            dram_addr_q  <= dram_addr_d;
            dram_wdata_q <= dram_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign o_gnt        = gnt_q;
    assign o_rvalid     = rvalid_q;
    assign o_rdata      = rdata_q;
    assign o_dram_en    = dram_en_q;
    assign o_dram_we    = dram_we_q;
    assign o_dram_addr  = dram_addr_q;
    assign o_dram_wdata = dram_wdata_q;
    assign o_busy       = busy_q;

endmodule
`default_nettype wire
